// File: rtl/sdr_app_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sdr_app_arbiter
//  Brief    : Two-port round-robin arbiter in front of the sdrc_core
//             application port. It grants one requester, holds the grant for
//             the whole transaction and steers the request, write-data and
//             read-data handshakes to the owner.
//  Revision : 1.0 - initial release
// ============================================================================
module sdr_app_arbiter #(
    parameter int APP_AW = 26,
    parameter int bl     = 9,
    parameter int dw     = 32
) (
    input  logic                sdram_clk,
    input  logic                resetn,
    input  logic                sdr_init_done,

    input  logic                p0_req,
    input  logic [APP_AW-1:0]   p0_req_addr,
    input  logic [bl-1:0]       p0_req_len,
    input  logic                p0_req_wr_n,
    output logic                p0_req_ack,
    input  logic [dw-1:0]       p0_wr_data,
    input  logic [dw/8-1:0]     p0_wr_en_n,
    output logic                p0_wr_next,
    output logic                p0_rd_valid,
    output logic                p0_last_rd,

    input  logic                p1_req,
    input  logic [APP_AW-1:0]   p1_req_addr,
    input  logic [bl-1:0]       p1_req_len,
    input  logic                p1_req_wr_n,
    output logic                p1_req_ack,
    input  logic [dw-1:0]       p1_wr_data,
    input  logic [dw/8-1:0]     p1_wr_en_n,
    output logic                p1_wr_next,
    output logic                p1_rd_valid,
    output logic                p1_last_rd,

    output logic [dw-1:0]       rd_data,

    output logic                app_req,
    output logic [APP_AW-1:0]   app_req_addr,
    output logic [bl-1:0]       app_req_len,
    output logic                app_req_wr_n,
    input  logic                app_req_ack,
    output logic [dw-1:0]       app_wr_data,
    output logic [dw/8-1:0]     app_wr_en_n,
    input  logic                app_wr_next_req,
    input  logic [dw-1:0]       app_rd_data,
    input  logic                app_rd_valid,
    input  logic                app_last_rd,

    output logic                owner,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WDATA = 2'd2,
        S_RDATA = 2'd3
    } state_t;

    localparam logic [bl-1:0] c_one = {{(bl-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_owner;
    logic               w_owner_nxt;
    logic               r_last_grant;
    logic               w_last_grant_nxt;
    logic [bl-1:0]      r_len;
    logic [bl-1:0]      w_len_nxt;
    logic [bl-1:0]      r_cnt;
    logic [bl-1:0]      w_cnt_nxt;

    logic [APP_AW-1:0]  w_own_addr;
    logic [bl-1:0]      w_own_len;
    logic               w_own_wr_n;
    logic [dw-1:0]      w_own_wr_data;
    logic [dw/8-1:0]    w_own_wr_en_n;
    logic [bl-1:0]      w_eff_len;
    logic [bl-1:0]      w_cnt_inc;
    logic               w_wr_route;
    logic               w_rd_route;

    // Request and write-data fields of whichever port currently owns the grant
    assign w_own_addr    = r_owner ? p1_req_addr : p0_req_addr;
    assign w_own_len     = r_owner ? p1_req_len  : p0_req_len;
    assign w_own_wr_n    = r_owner ? p1_req_wr_n : p0_req_wr_n;
    assign w_own_wr_data = r_owner ? p1_wr_data  : p0_wr_data;
    assign w_own_wr_en_n = r_owner ? p1_wr_en_n  : p0_wr_en_n;

    // A zero-length burst still moves one beat, so completion counts it as 1
    assign w_eff_len = (w_own_len == '0) ? c_one : w_own_len;
    assign w_cnt_inc = r_cnt + c_one;

    // Write beats are routed from the ack cycle onward; read beats only in RDATA
    assign w_wr_route = app_wr_next_req &&
                        ((r_state == S_WDATA) ||
                         ((r_state == S_REQ) && app_req_ack && !w_own_wr_n));
    assign w_rd_route = app_rd_valid && (r_state == S_RDATA);

    // State and bookkeeping registers, synchronous active-low reset
    always_ff @(posedge sdram_clk) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_len        <= '0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_len        <= w_len_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    // Arbitration and transaction progress: next state and bookkeeping values
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_grant_nxt = r_last_grant;
        w_len_nxt        = r_len;
        w_cnt_nxt        = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (sdr_init_done && (p0_req || p1_req)) begin
                    // On a tie the port that did not finish last wins
                    w_owner_nxt = (p0_req && p1_req) ? ~r_last_grant : p1_req;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (app_req_ack) begin
                    w_len_nxt = w_eff_len;
                    if (w_own_wr_n) begin
                        w_state_nxt = S_RDATA;
                    end else if (app_wr_next_req) begin
                        // A beat coincident with the ack counts toward the burst
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == w_eff_len) begin
                            w_state_nxt      = S_IDLE;
                            w_last_grant_nxt = r_owner;
                        end else begin
                            w_state_nxt = S_WDATA;
                        end
                    end else begin
                        w_state_nxt = S_WDATA;
                    end
                end
            end
            S_WDATA: begin
                if (app_wr_next_req) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        w_state_nxt      = S_IDLE;
                        w_last_grant_nxt = r_owner;
                    end
                end
            end
            S_RDATA: begin
                if (app_rd_valid && app_last_rd) begin
                    w_state_nxt      = S_IDLE;
                    w_last_grant_nxt = r_owner;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Steer core-side requests and per-port strobes to and from the owner
    always_comb begin
        app_req      = (r_state == S_REQ);
        app_req_addr = w_own_addr;
        app_req_len  = w_own_len;
        app_req_wr_n = w_own_wr_n;
        app_wr_data  = w_own_wr_data;
        app_wr_en_n  = '1;
        if ((r_state == S_REQ) || (r_state == S_WDATA)) begin
            app_wr_en_n = w_own_wr_en_n;
        end

        p0_req_ack  = app_req_ack && (r_state == S_REQ) && !r_owner;
        p1_req_ack  = app_req_ack && (r_state == S_REQ) &&  r_owner;
        p0_wr_next  = w_wr_route && !r_owner;
        p1_wr_next  = w_wr_route &&  r_owner;
        p0_rd_valid = w_rd_route && !r_owner;
        p1_rd_valid = w_rd_route &&  r_owner;
        p0_last_rd  = w_rd_route && app_last_rd && !r_owner;
        p1_last_rd  = w_rd_route && app_last_rd &&  r_owner;

        rd_data = app_rd_data;
        owner   = r_owner;
        busy    = (r_state != S_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_sdr_app_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdr_app_arbiter
//  Brief    : Directed pins plus randomized requester/core traffic for
//             sdr_app_arbiter, checked every cycle against a
//             transaction-level model of the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdr_app_arbiter;

    localparam int AW = 26;
    localparam int BL = 9;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          sdram_clk = 1'b0;
    logic          resetn;
    logic          sdr_init_done;
    logic          p0_req, p1_req;
    logic [AW-1:0] p0_req_addr, p1_req_addr;
    logic [BL-1:0] p0_req_len, p1_req_len;
    logic          p0_req_wr_n, p1_req_wr_n;
    logic          p0_req_ack, p1_req_ack;
    logic [DW-1:0] p0_wr_data, p1_wr_data;
    logic [BW-1:0] p0_wr_en_n, p1_wr_en_n;
    logic          p0_wr_next, p1_wr_next;
    logic          p0_rd_valid, p1_rd_valid;
    logic          p0_last_rd, p1_last_rd;
    logic [DW-1:0] rd_data;
    logic          app_req;
    logic [AW-1:0] app_req_addr;
    logic [BL-1:0] app_req_len;
    logic          app_req_wr_n;
    logic          app_req_ack;
    logic [DW-1:0] app_wr_data;
    logic [BW-1:0] app_wr_en_n;
    logic          app_wr_next_req;
    logic [DW-1:0] app_rd_data;
    logic          app_rd_valid;
    logic          app_last_rd;
    logic          owner;
    logic          busy;

    sdr_app_arbiter #(.APP_AW(AW), .bl(BL), .dw(DW)) dut (
        .sdram_clk(sdram_clk), .resetn(resetn), .sdr_init_done(sdr_init_done),
        .p0_req(p0_req), .p0_req_addr(p0_req_addr), .p0_req_len(p0_req_len),
        .p0_req_wr_n(p0_req_wr_n), .p0_req_ack(p0_req_ack), .p0_wr_data(p0_wr_data),
        .p0_wr_en_n(p0_wr_en_n), .p0_wr_next(p0_wr_next), .p0_rd_valid(p0_rd_valid),
        .p0_last_rd(p0_last_rd),
        .p1_req(p1_req), .p1_req_addr(p1_req_addr), .p1_req_len(p1_req_len),
        .p1_req_wr_n(p1_req_wr_n), .p1_req_ack(p1_req_ack), .p1_wr_data(p1_wr_data),
        .p1_wr_en_n(p1_wr_en_n), .p1_wr_next(p1_wr_next), .p1_rd_valid(p1_rd_valid),
        .p1_last_rd(p1_last_rd),
        .rd_data(rd_data),
        .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
        .app_req_wr_n(app_req_wr_n), .app_req_ack(app_req_ack), .app_wr_data(app_wr_data),
        .app_wr_en_n(app_wr_en_n), .app_wr_next_req(app_wr_next_req),
        .app_rd_data(app_rd_data), .app_rd_valid(app_rd_valid), .app_last_rd(app_last_rd),
        .owner(owner), .busy(busy)
    );

    always #5 sdram_clk = ~sdram_clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: is a transaction open, has the core accepted
    // it, which port owns it, how many write beats remain.
    // ------------------------------------------------------------------
    bit m_valid = 1'b0;
    bit m_busy, m_acked, m_own, m_last, m_write;
    int m_left;
    bit ackd [2];

    always @(negedge sdram_clk) begin
        logic          o_wr_n;
        logic [BL-1:0] o_len;
        logic [AW-1:0] o_addr;
        logic [DW-1:0] o_wd;
        logic [BW-1:0] o_en;
        bit            e_req, in_wr, in_rd, wr_phase, done;

        o_wr_n = m_own ? p1_req_wr_n : p0_req_wr_n;
        o_len  = m_own ? p1_req_len  : p0_req_len;
        o_addr = m_own ? p1_req_addr : p0_req_addr;
        o_wd   = m_own ? p1_wr_data  : p0_wr_data;
        o_en   = m_own ? p1_wr_en_n  : p0_wr_en_n;

        if (m_valid) begin
            e_req    = m_busy && !m_acked;
            wr_phase = m_busy && (!m_acked || m_write);
            in_wr    = m_busy && (m_acked ? m_write : (app_req_ack && !o_wr_n));
            in_rd    = m_busy && m_acked && !m_write;
            chk("busy", busy, m_busy);
            chk("app_req", app_req, e_req);
            chk("owner", owner, m_own);
            if (e_req) begin
                chk("app_req_addr", app_req_addr, o_addr);
                chk("app_req_len", app_req_len, o_len);
                chk("app_req_wr_n", app_req_wr_n, o_wr_n);
            end
            chk("p0_req_ack", p0_req_ack, e_req && app_req_ack && !m_own);
            chk("p1_req_ack", p1_req_ack, e_req && app_req_ack &&  m_own);
            chk("p0_wr_next", p0_wr_next, in_wr && app_wr_next_req && !m_own);
            chk("p1_wr_next", p1_wr_next, in_wr && app_wr_next_req &&  m_own);
            chk("app_wr_en_n", app_wr_en_n, wr_phase ? o_en : {BW{1'b1}});
            if (wr_phase) chk("app_wr_data", app_wr_data, o_wd);
            chk("p0_rd_valid", p0_rd_valid, in_rd && app_rd_valid && !m_own);
            chk("p1_rd_valid", p1_rd_valid, in_rd && app_rd_valid &&  m_own);
            chk("p0_last_rd", p0_last_rd, in_rd && app_rd_valid && app_last_rd && !m_own);
            chk("p1_last_rd", p1_last_rd, in_rd && app_rd_valid && app_last_rd &&  m_own);
            chk("rd_data", rd_data, app_rd_data);
        end

        if (p0_req_ack) ackd[0] = 1'b1;
        if (p1_req_ack) ackd[1] = 1'b1;

        // Advance the model to what the next clock edge produces
        done = 1'b0;
        if (!resetn) begin
            m_valid = 1'b1; m_busy = 1'b0; m_acked = 1'b0; m_own = 1'b0; m_last = 1'b1;
        end else if (m_valid) begin
            if (!m_busy) begin
                if (sdr_init_done && (p0_req || p1_req)) begin
                    m_own   = (p0_req && p1_req) ? !m_last : p1_req;
                    m_busy  = 1'b1;
                    m_acked = 1'b0;
                end
            end else if (!m_acked) begin
                if (app_req_ack) begin
                    m_acked = 1'b1;
                    m_write = !o_wr_n;
                    m_left  = (o_len == 0) ? 1 : int'(o_len);
                    if (m_write && app_wr_next_req) begin
                        m_left--;
                        done = (m_left == 0);
                    end
                end
            end else if (m_write) begin
                if (app_wr_next_req) begin
                    m_left--;
                    done = (m_left == 0);
                end
            end else begin
                done = app_rd_valid && app_last_rd;
            end
            if (done) begin
                m_busy = 1'b0;
                m_last = m_own;
            end
        end
    end

    task automatic step();
        @(posedge sdram_clk);
        #1;
    endtask

    // Random requester and core state
    bit            r_pend [2];
    logic [AW-1:0] r_addr [2];
    logic [BL-1:0] r_len  [2];
    logic          r_wr_n [2];
    int            core_ph;
    int            c_left;
    int            init_hold;

    initial begin
        resetn = 0; sdr_init_done = 0;
        p0_req = 0; p0_req_addr = '0; p0_req_len = '0; p0_req_wr_n = 1; p0_wr_data = '0; p0_wr_en_n = '1;
        p1_req = 0; p1_req_addr = '0; p1_req_len = '0; p1_req_wr_n = 1; p1_wr_data = '0; p1_wr_en_n = '1;
        app_req_ack = 0; app_wr_next_req = 0; app_rd_data = '0; app_rd_valid = 0; app_last_rd = 0;

        repeat (3) step();
        // Reset state
        @(negedge sdram_clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_app_req", app_req, 1'b0);
        chk("rst_owner", owner, 1'b0);
        chk("rst_wr_en_n", app_wr_en_n, 4'hF);

        // Init gating: p0 read held while init is not done
        step();
        resetn = 1;
        p0_req = 1; p0_req_addr = 26'h100; p0_req_len = 9'd2; p0_req_wr_n = 1;
        repeat (20) begin
            @(negedge sdram_clk);
            chk("gate_app_req", app_req, 1'b0);
        end
        // Init completes together with a p1 write request: a tie
        step();
        sdr_init_done = 1;
        p1_req = 1; p1_req_addr = 26'h200; p1_req_len = 9'd1; p1_req_wr_n = 0;
        p1_wr_data = 32'hCAFE_F00D; p1_wr_en_n = 4'h5;
        @(negedge sdram_clk);
        chk("pre_edge_app_req", app_req, 1'b0);
        step();
        app_req_ack = 1;
        @(negedge sdram_clk);
        chk("tie_owner", owner, 1'b0);
        chk("tie_app_req", app_req, 1'b1);
        chk("tie_addr", app_req_addr, 26'h100);
        chk("tie_p0_ack", p0_req_ack, 1'b1);
        chk("tie_p1_ack", p1_req_ack, 1'b0);
        step();
        p0_req = 0; app_req_ack = 0; app_rd_valid = 1; app_rd_data = 32'h1111_2222;
        @(negedge sdram_clk);
        chk("rd1_p0_valid", p0_rd_valid, 1'b1);
        chk("rd1_p1_valid", p1_rd_valid, 1'b0);
        chk("rd1_p0_last", p0_last_rd, 1'b0);
        chk("rd1_data", rd_data, 32'h1111_2222);
        step();
        app_last_rd = 1; app_rd_data = 32'h3333_4444;
        @(negedge sdram_clk);
        chk("rd2_p0_last", p0_last_rd, 1'b1);
        chk("rd2_p1_last", p1_last_rd, 1'b0);
        step();
        app_rd_valid = 0; app_last_rd = 0;
        @(negedge sdram_clk);
        chk("gap_busy", busy, 1'b0);
        chk("gap_app_req", app_req, 1'b0);
        // p1 granted next; len 1 write whose only beat coincides with ack
        step();
        app_req_ack = 1; app_wr_next_req = 1;
        @(negedge sdram_clk);
        chk("p1_owner", owner, 1'b1);
        chk("p1_app_req", app_req, 1'b1);
        chk("p1_wr_n", app_req_wr_n, 1'b0);
        chk("p1_ack", p1_req_ack, 1'b1);
        chk("p1_wr_next", p1_wr_next, 1'b1);
        chk("p0_wr_next_quiet", p0_wr_next, 1'b0);
        chk("p1_wr_en_n", app_wr_en_n, 4'h5);
        chk("p1_wr_data", app_wr_data, 32'hCAFE_F00D);
        step();
        app_req_ack = 0; app_wr_next_req = 0; p1_req = 0;
        @(negedge sdram_clk);
        chk("p1_done_busy", busy, 1'b0);
        chk("p1_done_wr_en_n", app_wr_en_n, 4'hF);
        // p0 write with len 0: a single beat completes it
        step();
        p0_req = 1; p0_req_len = 9'd0; p0_req_wr_n = 0;
        step();
        app_req_ack = 1;
        @(negedge sdram_clk);
        chk("len0_owner", owner, 1'b0);
        step();
        p0_req = 0; app_req_ack = 0; app_wr_next_req = 1;
        @(negedge sdram_clk);
        chk("len0_wr_next", p0_wr_next, 1'b1);
        chk("len0_busy", busy, 1'b1);
        step();
        app_wr_next_req = 0;
        @(negedge sdram_clk);
        chk("len0_done", busy, 1'b0);

        // Randomized traffic
        ackd[0] = 0; ackd[1] = 0;
        r_pend[0] = 0; r_pend[1] = 0;
        core_ph = 0; c_left = 0; init_hold = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            step();
            resetn = ($urandom % 300 != 0);
            if (!resetn) init_hold = $urandom_range(0, 15);
            sdr_init_done = (init_hold == 0);
            if (init_hold > 0) init_hold--;

            for (int n = 0; n < 2; n++) begin
                if (r_pend[n] && ackd[n]) begin
                    r_pend[n] = 0;
                end else if (!r_pend[n] && ($urandom % 4 == 0)) begin
                    r_pend[n] = 1;
                    r_addr[n] = AW'($urandom);
                    r_len[n]  = ($urandom % 16 == 0) ? BL'($urandom_range(7, 20)) : BL'($urandom_range(0, 6));
                    r_wr_n[n] = $urandom % 2;
                end
                ackd[n] = 0;
            end
            p0_req = r_pend[0]; p0_req_addr = r_addr[0]; p0_req_len = r_len[0]; p0_req_wr_n = r_wr_n[0];
            p1_req = r_pend[1]; p1_req_addr = r_addr[1]; p1_req_len = r_len[1]; p1_req_wr_n = r_wr_n[1];
            p0_wr_data = $urandom; p0_wr_en_n = BW'($urandom);
            p1_wr_data = $urandom; p1_wr_en_n = BW'($urandom);

            #1;
            app_req_ack = 0; app_wr_next_req = 0; app_rd_valid = 0; app_last_rd = 0;
            app_rd_data = $urandom;
            if (!resetn) begin
                core_ph = 0;
            end else if (core_ph == 0) begin
                if (app_req && ($urandom % 3 == 0)) begin
                    app_req_ack = 1;
                    c_left = (app_req_len == 0) ? 1 : int'(app_req_len);
                    if (!app_req_wr_n) begin
                        core_ph = 1;
                        if ($urandom % 2 == 1) begin
                            app_wr_next_req = 1;
                            c_left--;
                            if (c_left == 0) core_ph = 0;
                        end
                    end else begin
                        core_ph = 2;
                    end
                end else begin
                    app_wr_next_req = ($urandom % 8 == 0);
                    app_rd_valid    = ($urandom % 8 == 0);
                    app_last_rd     = $urandom % 2;
                end
            end else if (core_ph == 1) begin
                if ($urandom % 2 == 1) begin
                    app_wr_next_req = 1;
                    c_left--;
                    if (c_left == 0) core_ph = 0;
                end
            end else begin
                if ($urandom % 2 == 1) begin
                    app_rd_valid = 1;
                    app_last_rd  = (c_left == 1);
                    c_left--;
                    if (c_left == 0) core_ph = 0;
                end else begin
                    app_last_rd = $urandom % 2;
                end
            end
        end

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
